// File: rtl/dpram_tp_clr.sv
// rtl/dpram_tp_clr.sv - single-clock true dual-port RAM with clear sequencer
//
// Purpose: packet/header storage for the TLP datapath. Two independent
// read/write ports share one array. Same-address conflicts resolve
// deterministically: port A wins write/write conflicts, and a write is seen
// by a same-address read on the other port. Because reset cannot initialise
// RAM, a sweep writes CLR_VAL to every word after reset and on clr_req.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   en_a/we_a/addr_a/data_a, q_a   port A enable, write enable, address,
//                                  write data, registered read data
//   en_b/we_b/addr_b/data_b, q_b   port B, same as port A
//   clr_req             one-cycle request to sweep the array (IDLE only)
//   busy                high while the sweep runs; port accesses ignored
//   collision           one-cycle pulse after both ports wrote one address
//   perr_a, perr_b      (DPRAM_PARITY_EN only) read-back parity error flags
//
// Configuration: define DPRAM_PARITY_EN to store an even-parity bit per word
// and add the perr_a/perr_b outputs.

module dpram_tp_clr #(
  parameter int                DATA_W       = 8,
  parameter int                ADDR_W       = 6,
  parameter int                DEPTH        = 64,
  parameter logic [DATA_W-1:0] CLR_VAL      = '0,
  parameter bit                CLR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] q_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] q_b,
  input  logic              clr_req,
  output logic              busy,
  output logic              collision
`ifdef DPRAM_PARITY_EN
  ,
  output logic              perr_a,
  output logic              perr_b
`endif
);

`ifdef DPRAM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  // Stored word: parity bit (when enabled) above the data, chosen so the
  // whole word has an even number of ones.
  function automatic logic [WORD_W-1:0] enc(input logic [DATA_W-1:0] d);
`ifdef DPRAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  logic [WORD_W-1:0] mem [DEPTH];

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;

  logic              in_a, in_b;
  logic              wr_a, wr_b;
  logic              same_addr;
  logic              a_hits_b, b_hits_a;
  logic              both_wr;
  logic [WORD_W-1:0] rd_word_a, rd_word_b;

  always_comb begin
    in_a      = ({1'b0, addr_a} < DEPTH_L);
    in_b      = ({1'b0, addr_b} < DEPTH_L);
    wr_a      = en_a & we_a & in_a;
    wr_b      = en_b & we_b & in_b;
    same_addr = (addr_a == addr_b);
    // A write on one port forwarded into the other port's same-address access
    a_hits_b  = wr_a & en_b & same_addr;
    b_hits_a  = wr_b & en_a & same_addr;
    both_wr   = en_a & we_a & en_b & we_b & same_addr;
    rd_word_a = in_a ? mem[addr_a] : '0;
    rd_word_b = in_b ? mem[addr_b] : '0;
  end

  // Both ports and the sweep live in one process so conflicting writes to the
  // same word have a single, deterministic outcome.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_a       <= '0;
      q_b       <= '0;
      collision <= 1'b0;
      clr_addr  <= '0;
      state     <= CLR_ON_RESET ? CLEAR : IDLE;
      busy      <= CLR_ON_RESET;
`ifdef DPRAM_PARITY_EN
      perr_a    <= 1'b0;
      perr_b    <= 1'b0;
`endif
    end else if (state == CLEAR) begin
      mem[clr_addr] <= enc(CLR_VAL);
      collision     <= 1'b0;
      if (clr_addr == LAST_ADDR) begin
        clr_addr <= '0;
        state    <= IDLE;
        busy     <= 1'b0;
      end else begin
        clr_addr <= clr_addr + ADDR_W'(1);
      end
    end else begin
      // B first, then A, so A's data is what remains on a shared address
      if (wr_b && !(wr_a && same_addr))
        mem[addr_b] <= enc(data_b);
      if (wr_a)
        mem[addr_a] <= enc(data_a);

      if (en_a) begin
        if (we_a) begin
          q_a <= in_a ? data_a : '0;
`ifdef DPRAM_PARITY_EN
          perr_a <= 1'b0;
`endif
        end else if (b_hits_a) begin
          q_a <= data_b;
`ifdef DPRAM_PARITY_EN
          perr_a <= 1'b0;
`endif
        end else begin
          q_a <= rd_word_a[DATA_W-1:0];
`ifdef DPRAM_PARITY_EN
          perr_a <= ^rd_word_a;
`endif
        end
      end

      if (en_b) begin
        if (a_hits_b) begin
          q_b <= data_a;
`ifdef DPRAM_PARITY_EN
          perr_b <= 1'b0;
`endif
        end else if (we_b) begin
          q_b <= in_b ? data_b : '0;
`ifdef DPRAM_PARITY_EN
          perr_b <= 1'b0;
`endif
        end else begin
          q_b <= rd_word_b[DATA_W-1:0];
`ifdef DPRAM_PARITY_EN
          perr_b <= ^rd_word_b;
`endif
        end
      end

      collision <= both_wr;

      if (clr_req) begin
        state <= CLEAR;
        busy  <= 1'b1;
      end
    end
  end

endmodule
